// File: rtl/async_fifo_writer.sv
// Write-side distributor for the prefill FIFO bank. It takes one input stream and deals it
// round-robin to NUM_FIFO FIFOs in BURST-word groups, behind a single-entry hold register.
module async_fifo_writer #(
    parameter int DATA_WIDTH    = 16,
    parameter int NUM_FIFO      = 4,
    parameter int BURST         = 8,
    parameter int PREFILL_DEPTH = 16
) (
    input  logic                           wr_clk,
    input  logic                           wr_rstn,
    input  logic                           writer_en,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_WIDTH-1:0]          in_data,
    output logic [NUM_FIFO-1:0]            wr_en,
    input  logic [NUM_FIFO-1:0]            full,
    output logic [NUM_FIFO*DATA_WIDTH-1:0] wr_data,
    output logic [$clog2(NUM_FIFO)-1:0]    fifo_sel,
    output logic                           prefill_done
);

    // state   | meaning
    // IDLE    | waiting for writer_en, input not accepted
    // PREFILL | accepting words until every FIFO has its prefill share
    // STREAM  | continuous streaming, terminal until reset
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PREFILL = 2'd1;
    localparam logic [1:0] S_STREAM  = 2'd2;

    localparam int SEL_W  = $clog2(NUM_FIFO);
    localparam int TOTAL  = NUM_FIFO * PREFILL_DEPTH;
    localparam int CNT_W  = $clog2(TOTAL + 1);
    localparam int BEAT_W = (BURST > 1) ? $clog2(BURST) : 1;

    logic [1:0]            state_q, state_d;
    logic                  hold_valid_q, hold_valid_d;
    logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
    logic [SEL_W-1:0]      hold_sel_q, hold_sel_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic [CNT_W-1:0]      word_cnt_q, word_cnt_d;
    logic                  prefill_done_q, prefill_done_d;

    logic fire;
    logic accept;
    logic count_fire;

    assign fire       = hold_valid_q & ~full[hold_sel_q];
    assign in_ready   = writer_en & (state_q != S_IDLE) & (~hold_valid_q | fire);
    assign accept     = in_valid & in_ready;
    assign count_fire = fire & (word_cnt_q != CNT_W'(TOTAL));

    always_comb begin
        wr_en = '0;
        for (int k = 0; k < NUM_FIFO; k++) begin
            if (fire && (hold_sel_q == SEL_W'(k))) begin
                wr_en[k] = 1'b1;
            end
        end
    end

    assign wr_data      = {NUM_FIFO{hold_data_q}};
    assign fifo_sel     = sel_q;
    assign prefill_done = prefill_done_q;

    always_comb begin
        state_d        = state_q;
        hold_valid_d   = hold_valid_q;
        hold_data_d    = hold_data_q;
        hold_sel_d     = hold_sel_q;
        sel_d          = sel_q;
        beat_d         = beat_q;
        word_cnt_d     = word_cnt_q;
        prefill_done_d = prefill_done_q;

        case (state_q)
            S_IDLE: begin
                if (writer_en) begin
                    state_d = S_PREFILL;
                end
            end
            S_PREFILL: begin
                // words accepted so far = fired + the one still held
                if (accept && ((word_cnt_q + CNT_W'(hold_valid_q)) == CNT_W'(TOTAL - 1))) begin
                    state_d = S_STREAM;
                end
            end
            default: state_d = state_q;
        endcase

        if (accept) begin
            hold_valid_d = 1'b1;
            hold_data_d  = in_data;
            hold_sel_d   = sel_q;
            if (beat_q == BEAT_W'(BURST - 1)) begin
                beat_d = '0;
                sel_d  = (sel_q == SEL_W'(NUM_FIFO - 1)) ? '0 : sel_q + SEL_W'(1);
            end else begin
                beat_d = beat_q + BEAT_W'(1);
            end
        end else if (fire) begin
            hold_valid_d = 1'b0;
        end

        // the last prefill word may fire after entering STREAM, so count by value not state
        if (count_fire) begin
            word_cnt_d = word_cnt_q + CNT_W'(1);
            if (word_cnt_q == CNT_W'(TOTAL - 1)) begin
                prefill_done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge wr_clk or negedge wr_rstn) begin
        if (!wr_rstn) begin
            state_q        <= S_IDLE;
            hold_valid_q   <= 1'b0;
            hold_data_q    <= '0;
            hold_sel_q     <= '0;
            sel_q          <= '0;
            beat_q         <= '0;
            word_cnt_q     <= '0;
            prefill_done_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            hold_valid_q   <= hold_valid_d;
            hold_data_q    <= hold_data_d;
            hold_sel_q     <= hold_sel_d;
            sel_q          <= sel_d;
            beat_q         <= beat_d;
            word_cnt_q     <= word_cnt_d;
            prefill_done_q <= prefill_done_d;
        end
    end

endmodule

// File: tb/tb_async_fifo_writer.sv
// Directed and randomised bench for async_fifo_writer with a per-FIFO scoreboard.
module tb_async_fifo_writer;

    localparam int DW = 16;
    localparam int NF = 4;
    localparam int BU = 2;
    localparam int PD = 4;

    logic             wr_clk = 1'b0;
    logic             wr_rstn = 1'b0;
    logic             writer_en = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [DW-1:0]    in_data = '0;
    logic [NF-1:0]    wr_en;
    logic [NF-1:0]    full = '0;
    logic [NF*DW-1:0] wr_data;
    logic [1:0]       fifo_sel;
    logic             prefill_done;

    async_fifo_writer #(
        .DATA_WIDTH(DW), .NUM_FIFO(NF), .BURST(BU), .PREFILL_DEPTH(PD)
    ) dut (
        .wr_clk(wr_clk), .wr_rstn(wr_rstn), .writer_en(writer_en),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .wr_en(wr_en), .full(full), .wr_data(wr_data),
        .fifo_sel(fifo_sel), .prefill_done(prefill_done)
    );

    always #5 wr_clk = ~wr_clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change just after the rising edge; the task returns at the falling edge for sampling.
    task automatic drive(input logic en, input logic v, input logic [DW-1:0] d, input logic [NF-1:0] f);
        @(posedge wr_clk);
        #1;
        writer_en = en;
        in_valid  = v;
        in_data   = d;
        full      = f;
        @(negedge wr_clk);
    endtask

    logic [DW-1:0] exp_q[NF][$];
    logic [DW-1:0] got_q[NF][$];
    int            acc_cnt = 0;
    bit            mon_on = 1'b0;

    always @(negedge wr_clk) begin
        if (wr_rstn && mon_on) begin
            n_chk++;
            if (!$onehot0(wr_en)) begin
                n_fail++;
                $display("FAIL onehot_wr_en: got 0x%0h expected at most one bit", wr_en);
            end
            n_chk++;
            if ((wr_en & full) != '0) begin
                n_fail++;
                $display("FAIL write_while_full: wr_en 0x%0h full 0x%0h expected no overlap", wr_en, full);
            end
            for (int k = 0; k < NF; k++) begin
                if (wr_en[k]) got_q[k].push_back(wr_data[k*DW +: DW]);
            end
            if (in_valid && in_ready) begin
                exp_q[(acc_cnt / BU) % NF].push_back(in_data);
                acc_cnt++;
            end
        end
    end

    task automatic sb_check(input string name);
        bit ok;
        for (int k = 0; k < NF; k++) begin
            ok = (exp_q[k].size() == got_q[k].size());
            if (ok) begin
                for (int i = 0; i < exp_q[k].size(); i++) begin
                    if (exp_q[k][i] !== got_q[k][i]) ok = 1'b0;
                end
            end
            n_chk++;
            if (!ok) begin
                n_fail++;
                $display("FAIL %s_fifo%0d: got %0d words expected %0d words (or contents differ)",
                         name, k, got_q[k].size(), exp_q[k].size());
            end
            exp_q[k].delete();
            got_q[k].delete();
        end
    endtask

    task automatic async_reset(input string name);
        @(negedge wr_clk);
        #2;
        wr_rstn = 1'b0;
        #1;
        chk({name, "_wen"}, wr_en, 4'h0);
        chk({name, "_pd"}, prefill_done, 1'b0);
        chk({name, "_sel"}, fifo_sel, 2'd0);
        chk({name, "_rdy"}, in_ready, 1'b0);
        for (int k = 0; k < NF; k++) begin
            exp_q[k].delete();
            got_q[k].delete();
        end
        acc_cnt   = 0;
        writer_en = 1'b0;
        in_valid  = 1'b0;
        full      = '0;
        @(negedge wr_clk);
        wr_rstn = 1'b1;
    endtask

    typedef struct {
        logic          en;
        logic          vld;
        logic [DW-1:0] data;
        logic [NF-1:0] full;
        logic          rdy;
        logic [NF-1:0] wen;
        logic [DW-1:0] wdata;
        logic [1:0]    sel;
        logic          pd;
    } vec_t;

    vec_t          tbl[19];
    logic [DW-1:0] f0_exp[4];
    int            sent;
    int            cyc;
    logic [DW-1:0] d;
    logic          v;
    logic [NF-1:0] f;

    initial begin
        // contiguous prefill: word c-1 offered in row c, written one row later
        for (int c = 0; c < 19; c++) begin
            tbl[c].en    = 1'b1;
            tbl[c].full  = '0;
            tbl[c].vld   = (c <= 16);
            tbl[c].data  = (c >= 1 && c <= 16) ? 16'(c - 1) : 16'h0;
            tbl[c].rdy   = (c != 0);
            tbl[c].wen   = (c >= 2 && c <= 17) ? 4'(1 << (((c - 2) / 2) % 4)) : 4'h0;
            tbl[c].wdata = (c >= 2) ? 16'(c - 2) : 16'h0;
            tbl[c].sel   = (c == 0) ? 2'd0 : 2'(((c - 1) / 2) % 4);
            tbl[c].pd    = (c == 18);
        end
        f0_exp[0] = 16'h0; f0_exp[1] = 16'h1; f0_exp[2] = 16'h8; f0_exp[3] = 16'h9;

        #12;
        chk("rst_rdy", in_ready, 1'b0);
        chk("rst_wen", wr_en, 4'h0);
        chk("rst_wdata", wr_data, 64'h0);
        chk("rst_sel", fifo_sel, 2'd0);
        chk("rst_pd", prefill_done, 1'b0);
        @(negedge wr_clk);
        wr_rstn = 1'b1;
        mon_on  = 1'b1;

        for (int c = 0; c < 19; c++) begin
            drive(tbl[c].en, tbl[c].vld, tbl[c].data, tbl[c].full);
            chk($sformatf("pf%0d_rdy", c), in_ready, tbl[c].rdy);
            chk($sformatf("pf%0d_wen", c), wr_en, tbl[c].wen);
            chk($sformatf("pf%0d_sel", c), fifo_sel, tbl[c].sel);
            chk($sformatf("pf%0d_pd", c), prefill_done, tbl[c].pd);
            if (tbl[c].wen != '0) chk($sformatf("pf%0d_wdata", c), wr_data, {NF{tbl[c].wdata}});
        end
        chk("pf_fifo0_len", got_q[0].size(), 4);
        if (got_q[0].size() == 4) begin
            for (int i = 0; i < 4; i++) chk($sformatf("pf_fifo0_w%0d", i), got_q[0][i], f0_exp[i]);
        end
        sb_check("prefill");

        // backpressure on FIFO2 with an unrelated FIFO3 full beforehand
        drive(1, 1, 16'h100, 4'b0000); chk("bp0_rdy", in_ready, 1'b1);
        drive(1, 1, 16'h101, 4'b0000);
        drive(1, 1, 16'h102, 4'b1000); chk("bp2_rdy", in_ready, 1'b1); chk("bp2_wen", wr_en, 4'b0001);
        drive(1, 1, 16'h103, 4'b1000); chk("bp3_wen", wr_en, 4'b0010);
        drive(1, 1, 16'h104, 4'b1000); chk("bp4_wen", wr_en, 4'b0010);
        chk("bp4_wdata", wr_data[1*DW +: DW], 16'h103);
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 16'h105, 4'b0100);
            chk($sformatf("bp_stall%0d_rdy", i), in_ready, 1'b0);
            chk($sformatf("bp_stall%0d_wen", i), wr_en, 4'b0000);
            chk($sformatf("bp_stall%0d_hold", i), wr_data[2*DW +: DW], 16'h104);
        end
        drive(1, 1, 16'h105, 4'b0000);
        chk("bp_rel_rdy", in_ready, 1'b1); chk("bp_rel_wen", wr_en, 4'b0100);
        chk("bp_rel_wdata", wr_data[2*DW +: DW], 16'h104);
        drive(1, 0, 16'h0, 4'b0000);
        chk("bp_last_wen", wr_en, 4'b0100); chk("bp_last_wdata", wr_data[2*DW +: DW], 16'h105);
        drive(1, 0, 16'h0, 4'b0000); chk("bp_idle_wen", wr_en, 4'b0000);
        chk("bp_pd", prefill_done, 1'b1);
        sb_check("bp");

        async_reset("rst_stream");

        // reset in the middle of prefill with a write in flight
        drive(1, 1, 16'h200, 4'b0000); chk("rp_idle_rdy", in_ready, 1'b0);
        for (int i = 0; i < 6; i++) begin
            drive(1, 1, 16'(16'h200 + i), 4'b0000);
            chk($sformatf("rp%0d_rdy", i), in_ready, 1'b1);
        end
        drive(1, 1, 16'h206, 4'b0000);
        chk("rp_wen", wr_en, 4'b0100); chk("rp_wdata", wr_data[2*DW +: DW], 16'h205);
        async_reset("rst_prefill");

        // pause after the third accept, resume mid-burst
        drive(1, 1, 16'h300, 4'b0000); chk("pz0_rdy", in_ready, 1'b0);
        drive(1, 1, 16'h300, 4'b0000); chk("pz1_rdy", in_ready, 1'b1); chk("pz1_sel", fifo_sel, 2'd0);
        drive(1, 1, 16'h301, 4'b0000); chk("pz2_wen", wr_en, 4'b0001);
        drive(1, 1, 16'h302, 4'b0000); chk("pz3_wen", wr_en, 4'b0001);
        drive(0, 1, 16'h303, 4'b0000);
        chk("pz4_rdy", in_ready, 1'b0); chk("pz4_wen", wr_en, 4'b0010);
        chk("pz4_wdata", wr_data[1*DW +: DW], 16'h302); chk("pz4_sel", fifo_sel, 2'd1);
        drive(0, 1, 16'h303, 4'b0000); chk("pz5_rdy", in_ready, 1'b0); chk("pz5_wen", wr_en, 4'b0000);
        drive(1, 1, 16'h303, 4'b0000); chk("pz6_rdy", in_ready, 1'b1); chk("pz6_sel", fifo_sel, 2'd1);
        drive(1, 0, 16'h0, 4'b0000);
        chk("pz7_wen", wr_en, 4'b0010); chk("pz7_wdata", wr_data[1*DW +: DW], 16'h303);
        chk("pz7_sel", fifo_sel, 2'd2);
        drive(1, 0, 16'h0, 4'b0000); chk("pz8_wen", wr_en, 4'b0000); chk("pz8_sel", fifo_sel, 2'd2);
        sb_check("pause");

        // random valid and random full flags
        sent = 0;
        cyc  = 0;
        d    = 16'h400;
        while (sent < 64 && cyc < 3000) begin
            v = ($urandom_range(0, 3) != 0);
            f = NF'($urandom & $urandom);
            drive(1, v, d, f);
            if (v && in_ready) begin
                sent++;
                d++;
            end
            cyc++;
        end
        chk("rnd_sent", sent, 64);
        for (int i = 0; i < 4; i++) drive(1, 0, 16'h0, 4'b0000);
        chk("rnd_drained_wen", wr_en, 4'b0000);
        chk("rnd_pd", prefill_done, 1'b1);
        sb_check("rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

endmodule
